// File: rtl/rf_conv_accum_if.sv
// Feature-SRAM read port: the request is held until granted.
// Read data returns exactly one cycle after the grant.
interface rf_conv_accum_if #(
  parameter int ADDR_W = 16
);
  logic              o_mem_rd;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_gnt;
  logic [7:0]        i_mem_data;

  modport master (
    output o_mem_rd,
    output o_mem_addr,
    input  i_mem_gnt,
    input  i_mem_data
  );

  modport slave (
    input  o_mem_rd,
    input  o_mem_addr,
    output i_mem_gnt,
    output i_mem_data
  );
endinterface

// File: rtl/rf_conv_accum.sv
// Walks the RF list, fetches in-range pixels from feature SRAM
// and accumulates pixel*weight into one convolution output.
module rf_conv_accum #(
  parameter int IMG_H  = 28,
  parameter int IMG_W  = 28,
  parameter int LENGTH = 10,
  parameter int ADDR_W = 16,
  parameter int SUM_W  = 24
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [10:0]             i_length,
  input  logic [2:0][6:0]         i_RF [LENGTH],
  input  logic signed [7:0]       i_weight [LENGTH],
  rf_conv_accum_if.master         mem,
  output logic signed [SUM_W-1:0] o_sum,
  output logic                    o_busy,
  output logic                    o_finish
);
  localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [10:0]             len_q, len_d;
  logic                    rd_q, rd_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    pv_q, pv_d;
  logic signed [7:0]       pw_q, pw_d;
  logic signed [SUM_W-1:0] acc_q, acc_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic                    fin_q, fin_d;
  logic signed [16:0]      prod;
  logic [IW-1:0]           idx_nx;
  logic                    last;

  // Wrapped negative coordinates land above the bounds too.
  function automatic logic pad_of(
    input logic [2:0][6:0] e
  );
    return (32'(e[0]) >= 32'(IMG_H)) ||
           (32'(e[1]) >= 32'(IMG_W));
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [2:0][6:0] e
  );
    logic [31:0] a;
    a = 32'(e[2] & 7'h1f) * 32'(IMG_H * IMG_W)
      + 32'(e[0]) * 32'(IMG_W)
      + 32'(e[1]);
    return a[ADDR_W-1:0];
  endfunction

  always_comb begin
    prod    = $signed({1'b0, mem.i_mem_data}) * pw_q;
    idx_nx  = idx_q + 1'b1;
    last    = ({{(11-IW){1'b0}}, idx_q} == len_q - 11'd1);
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    pv_d    = 1'b0;
    pw_d    = pw_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    fin_d   = 1'b0;
    if (pv_q)
      acc_d = acc_q + {{(SUM_W-17){prod[16]}}, prod};
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          len_d = i_length;
          idx_d = '0;
          acc_d = '0;
          if (i_length == 11'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            rd_d    = !pad_of(i_RF[0]);
            addr_d  = addr_of(i_RF[0]);
          end
        end
      end
      S_FETCH: begin
        if (!rd_q || mem.i_mem_gnt) begin
          pv_d = rd_q;
          pw_d = i_weight[idx_q];
          if (last) begin
            state_d = S_DRAIN;
            rd_d    = 1'b0;
          end else begin
            idx_d  = idx_nx;
            rd_d   = !pad_of(i_RF[idx_nx]);
            addr_d = addr_of(i_RF[idx_nx]);
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Snapshot includes any product absorbed on the same edge.
    if (state_d == S_DONE) begin
      fin_d = 1'b1;
      sum_d = acc_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      pv_q    <= 1'b0;
      pw_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      pv_q    <= pv_d;
      pw_q    <= pw_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      fin_q   <= fin_d;
    end
  end

  assign mem.o_mem_rd   = rd_q;
  assign mem.o_mem_addr = addr_q;
  assign o_sum          = sum_q;
  assign o_finish       = fin_q;
  assign o_busy         = (state_q != S_IDLE);
endmodule
